// File: rtl/qcl_srff_bank.sv
// ============================================================================
//  Module   : qcl_srff_bank
//  Brief    : Bank of sticky set/reset status flags. Each flag has registered
//             edge pulses, a saturating rise counter and a sticky
//             collision log. The bank also drives an OR summary output.
//             Optional auto-clear timers are enabled by QCL_SRFF_AUTOCLR_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qcl_srff_bank #(
    parameter int                    channels_p      = 4,
    parameter int                    cnt_width_p     = 8,
    parameter int                    set_wins_p      = 1,
    parameter logic [channels_p-1:0] reset_val_p     = '0,
    parameter int                    timeout_width_p = 16
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [channels_p-1:0]             set_i,
    input  logic [channels_p-1:0]             clear_i,
    input  logic                              clear_all_i,
    output logic [channels_p-1:0]             data_o,
    output logic [channels_p-1:0]             rise_o,
    output logic [channels_p-1:0]             fall_o,
    output logic                              any_o,
    output logic [channels_p-1:0]             conflict_o,
    output logic [channels_p*cnt_width_p-1:0] set_cnt_o
`ifdef QCL_SRFF_AUTOCLR_EN
    ,
    input  logic [timeout_width_p-1:0]        timeout_i,
    output logic [channels_p-1:0]             timeout_o
`endif
);

    localparam logic c_set_wins = (set_wins_p != 0);

    logic [channels_p-1:0] w_nxt_vec;
    logic                  r_any;

    for (genvar c = 0; c < channels_p; c++) begin : g_ch
        logic                   w_nxt;
        logic                   w_auto;
        logic                   w_rise_nxt;
        logic                   w_fall_nxt;
        logic                   r_flag;
        logic                   r_rise;
        logic                   r_fall;
        logic                   r_conf;
        logic [cnt_width_p-1:0] r_cnt;

`ifdef QCL_SRFF_AUTOCLR_EN
        logic [timeout_width_p-1:0] r_timer;
        logic [timeout_width_p:0]   w_elapsed;
        logic                       w_tmo_nxt;
        logic                       r_tmo;

        // Elapsed cycles counting the current one; one bit wider so a
        // saturated timer can never wrap the comparison.
        always_comb begin
            w_elapsed = {1'b0, r_timer} + (timeout_width_p+1)'(1);
            w_auto    = (timeout_i != '0) && r_flag &&
                        (w_elapsed >= {1'b0, timeout_i});
            w_tmo_nxt = w_auto && !clear_all_i && !set_i[c] && !clear_i[c];
        end

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_timer <= '0;
                r_tmo   <= 1'b0;
            end else begin
                r_tmo <= w_tmo_nxt;
                if (clear_all_i || !w_nxt || set_i[c])
                    r_timer <= '0;
                else if (r_timer != '1)
                    r_timer <= r_timer + timeout_width_p'(1);
            end
        end

        assign timeout_o[c] = r_tmo;
`else
        assign w_auto = 1'b0;
`endif

        // Priority: bulk clear, collision, set, clear, auto-clear, hold.
        always_comb begin
            w_nxt = r_flag;
            if (clear_all_i)
                w_nxt = reset_val_p[c];
            else if (set_i[c] && clear_i[c])
                w_nxt = c_set_wins;
            else if (set_i[c])
                w_nxt = 1'b1;
            else if (clear_i[c])
                w_nxt = 1'b0;
            else if (w_auto)
                w_nxt = 1'b0;
        end

        assign w_rise_nxt = !clear_all_i && !r_flag && w_nxt;
        assign w_fall_nxt = !clear_all_i && r_flag && !w_nxt;

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_flag <= reset_val_p[c];
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                r_conf <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_flag <= w_nxt;
                r_rise <= w_rise_nxt;
                r_fall <= w_fall_nxt;
                if (clear_all_i) begin
                    r_conf <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    r_conf <= r_conf | (set_i[c] & clear_i[c]);
                    if (w_rise_nxt && (r_cnt != '1))
                        r_cnt <= r_cnt + cnt_width_p'(1);
                end
            end
        end

        assign w_nxt_vec[c]                            = w_nxt;
        assign data_o[c]                               = r_flag;
        assign rise_o[c]                               = r_rise;
        assign fall_o[c]                               = r_fall;
        assign conflict_o[c]                           = r_conf;
        assign set_cnt_o[c*cnt_width_p +: cnt_width_p] = r_cnt;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            r_any <= |reset_val_p;
        else
            r_any <= |w_nxt_vec;
    end

    assign any_o = r_any;

endmodule

`default_nettype wire

// File: tb/tb_qcl_srff_bank.sv
// ============================================================================
//  Module   : tb_qcl_srff_bank
//  Brief    : Self-checking bench for qcl_srff_bank. It runs a vector table
//             and a scoreboard, then hand sequences for reset, saturation and
//             auto-clear.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qcl_srff_bank;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  set_v, clr_v;
    logic        ca;
    logic [3:0]  d1, rise1, fall1, conf1, d0, rise0, fall0, conf0;
    logic        any1, any0;
    logic [31:0] cnt1, cnt0;
`ifdef QCL_SRFF_AUTOCLR_EN
    logic [15:0] tmo_in;
    logic [3:0]  tmo1, tmo0;
`endif

    always #5 clk = ~clk;

    qcl_srff_bank #(
        .channels_p(4), .cnt_width_p(8), .set_wins_p(1),
        .reset_val_p(4'b0101), .timeout_width_p(16)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .set_i(set_v), .clear_i(clr_v),
        .clear_all_i(ca), .data_o(d1), .rise_o(rise1), .fall_o(fall1),
        .any_o(any1), .conflict_o(conf1), .set_cnt_o(cnt1)
`ifdef QCL_SRFF_AUTOCLR_EN
        , .timeout_i(tmo_in), .timeout_o(tmo1)
`endif
    );

    qcl_srff_bank #(
        .channels_p(4), .cnt_width_p(8), .set_wins_p(0),
        .reset_val_p(4'b0000), .timeout_width_p(16)
    ) dut_cw (
        .clk_i(clk), .reset_n_i(reset_n), .set_i(set_v), .clear_i(clr_v),
        .clear_all_i(ca), .data_o(d0), .rise_o(rise0), .fall_o(fall0),
        .any_o(any0), .conflict_o(conf0), .set_cnt_o(cnt0)
`ifdef QCL_SRFF_AUTOCLR_EN
        , .timeout_i(tmo_in), .timeout_o(tmo0)
`endif
    );

    typedef struct {
        logic [3:0] set;
        logic [3:0] clr;
        logic       ca;
        logic [3:0] d;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] conf;
        logic [3:0] d0;
    } vec_t;

    typedef struct {
        logic [3:0] d;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] conf;
        logic [3:0] d0;
        logic       ca;
    } exp_t;

    vec_t tbl[12];
    exp_t sb[$];
    logic [7:0] m_cnt[4];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] s, input logic [3:0] c, input logic a);
        set_v = s;
        clr_v = c;
        ca    = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        //            set      clr      ca    d        rise     fall     conf     d0
        tbl[0]  = '{4'b0000, 4'b0101, 1'b0, 4'b0000, 4'b0000, 4'b0101, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100};
        tbl[2]  = '{4'b0000, 4'b0000, 1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
        tbl[3]  = '{4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
        tbl[4]  = '{4'b0010, 4'b0010, 1'b0, 4'b0110, 4'b0010, 4'b0000, 4'b0010, 4'b0100};
        tbl[5]  = '{4'b1001, 4'b0100, 1'b0, 4'b1011, 4'b1001, 4'b0100, 4'b0010, 4'b1001};
        tbl[6]  = '{4'b0000, 4'b0010, 1'b0, 4'b1001, 4'b0000, 4'b0010, 4'b0010, 4'b1001};
        tbl[7]  = '{4'b1111, 4'b0000, 1'b1, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[8]  = '{4'b0000, 4'b0000, 1'b0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[9]  = '{4'b1010, 4'b1111, 1'b0, 4'b1010, 4'b1010, 4'b0101, 4'b1010, 4'b0000};
        tbl[10] = '{4'b0000, 4'b0000, 1'b0, 4'b1010, 4'b0000, 4'b0000, 4'b1010, 4'b0000};
        tbl[11] = '{4'b0000, 4'b0000, 1'b1, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

        reset_n = 1'b0;
        set_v = '0;
        clr_v = '0;
        ca = 1'b0;
`ifdef QCL_SRFF_AUTOCLR_EN
        tmo_in = '0;
`endif
        for (int c = 0; c < 4; c++) m_cnt[c] = 8'd0;
        #12;
        check("reset_data", d1, 4'b0101);
        check("reset_any", any1, 1'b1);
        check("reset_cnt", cnt1, 32'd0);
        check("reset_conf", conf1, 4'b0000);
        check("reset_data_cw", d0, 4'b0000);
        check("reset_any_cw", any0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            sb.push_back('{tbl[i].d, tbl[i].rise, tbl[i].fall, tbl[i].conf, tbl[i].d0, tbl[i].ca});
            step(tbl[i].set, tbl[i].clr, tbl[i].ca);
            e = sb.pop_front();
            check($sformatf("vec%0d_data", i), d1, e.d);
            check($sformatf("vec%0d_rise", i), rise1, e.rise);
            check($sformatf("vec%0d_fall", i), fall1, e.fall);
            check($sformatf("vec%0d_conf", i), conf1, e.conf);
            check($sformatf("vec%0d_any", i), any1, |e.d);
            check($sformatf("vec%0d_data_cw", i), d0, e.d0);
            check($sformatf("vec%0d_conf_cw", i), conf0, e.conf);
            for (int c = 0; c < 4; c++) begin
                if (e.ca) m_cnt[c] = 8'd0;
                else if (e.rise[c] && m_cnt[c] != 8'hFF) m_cnt[c] = m_cnt[c] + 8'd1;
            end
            check($sformatf("vec%0d_cnt", i), cnt1, {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]});
        end

        // Asynchronous reset while flags, pulses and counters are live.
        step(4'b1010, 4'b1000, 1'b0);
        check("pre_rst_data", d1, 4'b1111);
        check("pre_rst_rise", rise1, 4'b1010);
        check("pre_rst_cnt", cnt1, 32'h0100_0100);
        set_v = '0;
        clr_v = '0;
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_data", d1, 4'b0101);
        check("async_rst_rise", rise1, 4'b0000);
        check("async_rst_fall", fall1, 4'b0000);
        check("async_rst_conf", conf1, 4'b0000);
        check("async_rst_cnt", cnt1, 32'd0);
        check("async_rst_any", any1, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;

        // Counter saturation on channel 0.
        for (int k = 0; k < 300; k++) begin
            step(4'b0001, 4'b0000, 1'b0);
            step(4'b0000, 4'b0001, 1'b0);
        end
        check("sat_cnt", cnt1, 32'h0000_00FF);
        step(4'b0001, 4'b0000, 1'b0);
        check("sat_rise", rise1, 4'b0001);
        check("sat_hold", cnt1, 32'h0000_00FF);

`ifdef QCL_SRFF_AUTOCLR_EN
        tmo_in = 16'd5;
        step(4'b0000, 4'b1000, 1'b0);
        step(4'b1000, 4'b0000, 1'b0);
        check("tmo_T1_data", d1[3], 1'b1);
        for (int k = 2; k <= 6; k++) begin
            step(4'b0000, 4'b0000, 1'b0);
            check($sformatf("tmo_T%0d_data", k), d1[3], (k <= 5) ? 1'b1 : 1'b0);
            check($sformatf("tmo_T%0d_tmo", k), tmo1[3], (k == 6) ? 1'b1 : 1'b0);
            check($sformatf("tmo_T%0d_fall", k), fall1[3], (k == 6) ? 1'b1 : 1'b0);
        end
        step(4'b1000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b1000, 4'b0000, 1'b0);
        for (int k = 5; k <= 9; k++) begin
            step(4'b0000, 4'b0000, 1'b0);
            check($sformatf("rearm_T%0d_data", k), d1[3], (k <= 8) ? 1'b1 : 1'b0);
            check($sformatf("rearm_T%0d_tmo", k), tmo1[3], (k == 9) ? 1'b1 : 1'b0);
        end
        tmo_in = '0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
